writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage of the core. Accepts completed results from the ALU channel and the load channel, applies sub-word extraction and sign/zero extension to load data, and arbitrates both onto the single register-file write port as a registered `register_file_write_t`. Provides backpressure on each channel. A one-entry ALU hold buffer lets the ALU channel keep moving while a load occupies the port.

## Interface
- `StarveLimit`, default 4: consecutive cycles a held ALU result may lose arbitration before the load channel is blocked.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `alu_valid_i`  in  1  ALU result present.
- `alu_ready_o`  out  1  ALU result accepted this cycle when both valid and ready are high.
- `alu_rd_i`  in  5  destination register.
- `alu_data_i`  in  32  result.
- `load_valid_i`  in  1  load result present.
- `load_ready_o`  out  1  load result accepted this cycle when both valid and ready are high.
- `load_rd_i`  in  5  destination register.
- `load_data_i`  in  32  raw aligned memory word.
- `load_funct3_i`  in  3  RV32I load funct3.
- `load_offset_i`  in  2  byte address bits [1:0].
- `write_o`  out  struct  `register_file_write_t` {enable, address[4:0], data[31:0]} to the register file.
- `retire_count_o`  out  32  enabled writes issued.
- `conflict_count_o`  out  32  cycles in which the hold buffer lost to a load.

## Operation
- Hold buffer has fields valid, rd and data. `alu_ready_o` = !hold.valid && !rst_i.
- Starve counter is 0..StarveLimit. Blocking is asserted when the counter equals StarveLimit. `load_ready_o` = !blocking && !rst_i.
- Arbitration per cycle, in priority order:
  1. Blocking: the hold buffer drains to the output.
  2. A load is accepted: the load drains. If the hold buffer is empty and an ALU result is accepted in the same cycle, that ALU result goes into the hold buffer.
  3. The hold buffer is valid: the hold buffer drains.
  4. An ALU result is accepted: the ALU result drains directly.
  5. Otherwise the output enable is 0 next cycle.
- Starve counter behaviour:
  - Increments in each cycle where the hold buffer is valid and a load wins.
  - Clears when the hold buffer drains.
- Load extension, where b = byte at `load_offset_i` and h = half selected by `load_offset_i[1]`:
  - LB (000): sign-extend b.
  - LH (001): sign-extend h.
  - LW (010): word unchanged.
  - LBU (100): zero-extend b.
  - LHU (101): zero-extend h.
  - Any other funct3: word unchanged.
- Entries with rd = 0 are accepted and consumed normally. They produce `write_o.enable` = 0 and are not counted.
- Issue logic guarantees no WAW hazard between outstanding ALU and load results. This block does no reordering checks.
- Counters wrap from 2^32-1 to 0.

## Timing
- `write_o` is registered. An entry that drains in cycle N appears on `write_o` in N+1 for exactly one cycle.
- Sustained throughput is one write per cycle.
- ALU end-to-end latency is 1 cycle, or 2+ cycles when the result is held.
- The ready outputs depend only on registered state and `rst_i`. There is no combinational path from any valid input to any ready output.
- Reset values:
  - `write_o` enable, address and data are 0.
  - Hold buffer is empty; starve counter is 0; both counters are 0.
  - Both ready outputs are 0 while `rst_i` is high.
- Reset asserted mid-operation discards the held entry and any in-flight output immediately. No write is issued for them.
- First accept can occur in the first rising edge after `rst_i` deasserts.

## Configuration
- `WRITEBACK_STATS_EN` defined: `retire_count_o` and `conflict_count_o` counters are implemented as described.
- `WRITEBACK_STATS_EN` undefined: the counters are not built, and both outputs are tied to 0.
- Arbitration and data behaviour are identical in both builds.

## Test plan
- **Single ALU result:** ALU valid with rd=5, data=0x1234_5678 in cycle 0 → `write_o` = {1, 5, 0x1234_5678} in cycle 1 only, and `alu_ready_o` stays 1.
- **Load sign/zero extension:** load word 0x80FF_7F01 →
  - LB offset 3 → 0xFFFF_FF80.
  - LBU offset 3 → 0x0000_0080.
  - LH offset 2 → 0xFFFF_80FF.
  - LHU offset 0 → 0x0000_7F01.
- **Simultaneous ALU and load:** ALU (rd=1, 0xA) and load (rd=2, LW 0xB) both valid in cycle 0 → cycle 1 writes rd=2 with 0xB, cycle 2 writes rd=1 with 0xA, and `alu_ready_o` = 0 in cycle 1.
- **Starvation:** hold buffer valid, loads continuously valid → after 4 lost cycles `load_ready_o` drops for one cycle, the held ALU write issues, then `load_ready_o` returns to 1. With `WRITEBACK_STATS_EN` defined, `conflict_count_o` = 4.
- **rd = 0:** ALU result with rd=0, data=0xDEAD → accepted, `write_o.enable` = 0 in the next cycle, `retire_count_o` unchanged.
- **Reset mid-operation:** `rst_i` pulses asynchronously while the hold buffer is valid → `write_o` is 0 immediately, the held entry is never written, and both ready outputs are 0 until release.

Source files
------------

// File: rtl/writeback_stage_if.sv
// Register-file write record and the writeback channel interface (ALU in, load in, write port out).
package writeback_pkg;
  typedef struct packed {
    logic        enable;
    logic [4:0]  address;
    logic [31:0] data;
  } register_file_write_t;
endpackage

interface writeback_stage_if;
  import writeback_pkg::*;
  logic                 alu_valid_i;
  logic                 alu_ready_o;
  logic [4:0]           alu_rd_i;
  logic [31:0]          alu_data_i;
  logic                 load_valid_i;
  logic                 load_ready_o;
  logic [4:0]           load_rd_i;
  logic [31:0]          load_data_i;
  logic [2:0]           load_funct3_i;
  logic [1:0]           load_offset_i;
  register_file_write_t write_o;
  logic [31:0]          retire_count_o;
  logic [31:0]          conflict_count_o;

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output load_valid_i, load_rd_i, load_data_i, load_funct3_i, load_offset_i,
    input  alu_ready_o, load_ready_o, write_o, retire_count_o, conflict_count_o
  );
  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  load_valid_i, load_rd_i, load_data_i, load_funct3_i, load_offset_i,
    output alu_ready_o, load_ready_o, write_o, retire_count_o, conflict_count_o
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback arbiter: load extension, one-entry ALU hold buffer, starvation guard, registered write port.
// Optional statistics counters are built when WRITEBACK_STATS_EN is defined.
module writeback_stage
  import writeback_pkg::*;
#(
  parameter int StarveLimit = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  writeback_stage_if.slave wb
);
  localparam int CW = $clog2(StarveLimit + 1);

  logic          hold_v;
  logic [4:0]    hold_rd;
  logic [31:0]   hold_data;
  logic [CW-1:0] starve_cnt;
  register_file_write_t write_q;

  logic        blocking, alu_acc, load_acc;
  logic        drain_v, hold_load, hold_clr, starve_inc;
  logic [4:0]  drain_rd;
  logic [31:0] drain_data, load_ext;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f3,
                                         input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extend = {{24{b[7]}}, b};
      3'b001:  extend = {{16{h[15]}}, h};
      3'b100:  extend = {24'd0, b};
      3'b101:  extend = {16'd0, h};
      default: extend = w;
    endcase
  endfunction

  // Readies come from registered state only, so no valid-to-ready path exists.
  assign blocking        = (starve_cnt == CW'(StarveLimit));
  assign wb.alu_ready_o  = !hold_v && !rst_i;
  assign wb.load_ready_o = !blocking && !rst_i;
  assign alu_acc         = wb.alu_valid_i && wb.alu_ready_o;
  assign load_acc        = wb.load_valid_i && wb.load_ready_o;
  assign load_ext        = extend(wb.load_data_i, wb.load_funct3_i, wb.load_offset_i);

  always_comb begin
    drain_v    = 1'b0;
    drain_rd   = '0;
    drain_data = '0;
    hold_load  = 1'b0;
    hold_clr   = 1'b0;
    starve_inc = 1'b0;
    if (blocking) begin
      drain_v = 1'b1; drain_rd = hold_rd; drain_data = hold_data; hold_clr = 1'b1;
    end else if (load_acc) begin
      drain_v = 1'b1; drain_rd = wb.load_rd_i; drain_data = load_ext;
      starve_inc = hold_v;
      hold_load  = alu_acc;
    end else if (hold_v) begin
      drain_v = 1'b1; drain_rd = hold_rd; drain_data = hold_data; hold_clr = 1'b1;
    end else if (alu_acc) begin
      drain_v = 1'b1; drain_rd = wb.alu_rd_i; drain_data = wb.alu_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_v     <= 1'b0;
      hold_rd    <= '0;
      hold_data  <= '0;
      starve_cnt <= '0;
      write_q    <= '0;
    end else begin
      write_q.enable  <= drain_v && (drain_rd != 5'd0);
      write_q.address <= drain_rd;
      write_q.data    <= drain_data;
      if (hold_clr) hold_v <= 1'b0;
      else if (hold_load) begin
        hold_v    <= 1'b1;
        hold_rd   <= wb.alu_rd_i;
        hold_data <= wb.alu_data_i;
      end
      if (hold_clr) starve_cnt <= '0;
      else if (starve_inc) starve_cnt <= starve_cnt + CW'(1);
    end
  end

  assign wb.write_o = write_q;

`ifdef WRITEBACK_STATS_EN
  logic [31:0] retire_q, conflict_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retire_q   <= '0;
      conflict_q <= '0;
    end else begin
      if (drain_v && (drain_rd != 5'd0)) retire_q <= retire_q + 32'd1;
      if (starve_inc) conflict_q <= conflict_q + 32'd1;
    end
  end
  assign wb.retire_count_o   = retire_q;
  assign wb.conflict_count_o = conflict_q;
`else
  assign wb.retire_count_o   = 32'd0;
  assign wb.conflict_count_o = 32'd0;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: reset, ALU path, load extension, arbitration, starvation, rd=0, mid-run reset.
module tb_writeback_stage;
  import writeback_pkg::*;

`ifdef WRITEBACK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   errors = 0;
  int   checks = 0;

  writeback_stage_if wbif();
  writeback_stage #(.StarveLimit(4)) dut (.clk_i(clk_i), .rst_i(rst_i), .wb(wbif.slave));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    return 64'({en, a, d});
  endfunction

  function automatic logic [63:0] cnt(input int v);
    return STATS ? 64'(v) : 64'd0;
  endfunction

  task automatic idle_inputs();
    wbif.alu_valid_i = 0; wbif.alu_rd_i = 0; wbif.alu_data_i = 0;
    wbif.load_valid_i = 0; wbif.load_rd_i = 0; wbif.load_data_i = 0;
    wbif.load_funct3_i = 0; wbif.load_offset_i = 0;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [31:0] d,
                            input logic [2:0] f3, input logic [1:0] off);
    wbif.load_valid_i = 1; wbif.load_rd_i = rd; wbif.load_data_i = d;
    wbif.load_funct3_i = f3; wbif.load_offset_i = off;
  endtask

  logic [2:0]  lf3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
  logic [1:0]  loff [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1};
  logic [31:0] lexp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

  initial begin
    idle_inputs();
    // reset state
    @(negedge clk_i);
    chk("rst_write", 64'(wbif.write_o), 64'd0);
    chk("rst_alu_ready", 64'(wbif.alu_ready_o), 64'd0);
    chk("rst_load_ready", 64'(wbif.load_ready_o), 64'd0);
    chk("rst_retire", 64'(wbif.retire_count_o), 64'd0);
    rst_i = 0;
    #1;
    chk("rel_alu_ready", 64'(wbif.alu_ready_o), 64'd1);
    chk("rel_load_ready", 64'(wbif.load_ready_o), 64'd1);

    // single ALU result
    wbif.alu_valid_i = 1; wbif.alu_rd_i = 5; wbif.alu_data_i = 32'h1234_5678;
    @(negedge clk_i);
    idle_inputs();
    chk("alu_write", 64'(wbif.write_o), wr(1, 5, 32'h1234_5678));
    chk("alu_ready_kept", 64'(wbif.alu_ready_o), 64'd1);
    @(negedge clk_i);
    chk("alu_one_cycle", 64'(wbif.write_o.enable), 64'd0);
    chk("alu_retire", 64'(wbif.retire_count_o), cnt(1));

    // back-to-back loads with extension
    for (int i = 0; i < 5; i++) begin
      drive_load(5'd3, 32'h80FF_7F01, lf3[i], loff[i]);
      @(negedge clk_i);
      chk($sformatf("load_ext%0d", i), 64'(wbif.write_o), wr(1, 3, lexp[i]));
    end
    idle_inputs();
    @(negedge clk_i);
    chk("load_idle", 64'(wbif.write_o.enable), 64'd0);
    chk("load_retire", 64'(wbif.retire_count_o), cnt(6));

    // simultaneous ALU and load
    wbif.alu_valid_i = 1; wbif.alu_rd_i = 1; wbif.alu_data_i = 32'hA;
    drive_load(5'd2, 32'hB, 3'b010, 2'd0);
    @(negedge clk_i);
    idle_inputs();
    chk("sim_load_first", 64'(wbif.write_o), wr(1, 2, 32'hB));
    chk("sim_alu_ready", 64'(wbif.alu_ready_o), 64'd0);
    @(negedge clk_i);
    chk("sim_alu_second", 64'(wbif.write_o), wr(1, 1, 32'hA));
    chk("sim_alu_ready_back", 64'(wbif.alu_ready_o), 64'd1);
    @(negedge clk_i);
    chk("sim_idle", 64'(wbif.write_o.enable), 64'd0);

    // starvation: hold valid while loads stream
    wbif.alu_valid_i = 1; wbif.alu_rd_i = 7; wbif.alu_data_i = 32'h77;
    drive_load(5'd8, 32'h55, 3'b010, 2'd0);
    @(negedge clk_i);
    wbif.alu_valid_i = 0;
    chk("stv_alu_ready", 64'(wbif.alu_ready_o), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("stv_load_w%0d", i), 64'(wbif.write_o), wr(1, 8, 32'h55));
      chk($sformatf("stv_ready%0d", i), 64'(wbif.load_ready_o), 64'd1);
      @(negedge clk_i);
    end
    chk("stv_load_w5", 64'(wbif.write_o), wr(1, 8, 32'h55));
    chk("stv_blocked", 64'(wbif.load_ready_o), 64'd0);
    chk("stv_conflicts", 64'(wbif.conflict_count_o), cnt(4));
    @(negedge clk_i);
    idle_inputs();
    chk("stv_held_write", 64'(wbif.write_o), wr(1, 7, 32'h77));
    chk("stv_ready_back", 64'(wbif.load_ready_o), 64'd1);
    chk("stv_alu_ready_back", 64'(wbif.alu_ready_o), 64'd1);
    @(negedge clk_i);
    chk("stv_retire", 64'(wbif.retire_count_o), cnt(14));

    // rd = 0 is consumed but not written or counted
    wbif.alu_valid_i = 1; wbif.alu_rd_i = 0; wbif.alu_data_i = 32'hDEAD;
    #1;
    chk("rd0_ready", 64'(wbif.alu_ready_o), 64'd1);
    @(negedge clk_i);
    idle_inputs();
    chk("rd0_enable", 64'(wbif.write_o.enable), 64'd0);
    chk("rd0_retire", 64'(wbif.retire_count_o), cnt(14));
    chk("rd0_not_held", 64'(wbif.alu_ready_o), 64'd1);

    // reset mid-operation with hold buffer occupied
    wbif.alu_valid_i = 1; wbif.alu_rd_i = 9; wbif.alu_data_i = 32'h99;
    drive_load(5'd10, 32'h1010, 3'b010, 2'd0);
    @(negedge clk_i);
    idle_inputs();
    chk("mr_load_write", 64'(wbif.write_o), wr(1, 10, 32'h1010));
    #2 rst_i = 1;
    #1;
    chk("mr_write_cleared", 64'(wbif.write_o), 64'd0);
    chk("mr_alu_ready", 64'(wbif.alu_ready_o), 64'd0);
    chk("mr_load_ready", 64'(wbif.load_ready_o), 64'd0);
    chk("mr_retire_cleared", 64'(wbif.retire_count_o), 64'd0);
    @(negedge clk_i);
    chk("mr_still_ready0", 64'(wbif.alu_ready_o), 64'd0);
    rst_i = 0;
    @(negedge clk_i);
    chk("mr_no_held_write", 64'(wbif.write_o.enable), 64'd0);
    chk("mr_alu_ready_back", 64'(wbif.alu_ready_o), 64'd1);
    chk("mr_load_ready_back", 64'(wbif.load_ready_o), 64'd1);
    @(negedge clk_i);
    chk("mr_no_late_write", 64'(wbif.write_o.enable), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
